// File: rtl/top_mod.sv
// top_mod: 640x480@60Hz VGA timing generator with an eight-bar RGB565 test pattern.
//   clk    in   50 MHz board clock, every pixel spans two clk cycles
//   rst    in   synchronous active-high reset, restarts the frame at pixel (0,0)
//   Hsync  out  horizontal sync, active low, registered
//   Vsync  out  vertical sync, active low, registered
//   Red    out  5-bit red, registered, 0 outside the visible area
//   Green  out  6-bit green, registered, 0 outside the visible area
//   Blue   out  5-bit blue, registered, 0 outside the visible area
module top_mod #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       Hsync,
    output logic       Vsync,
    output logic [4:0] Red,
    output logic [5:0] Green,
    output logic [4:0] Blue
);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] H_MAX = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_LO = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
    localparam logic [9:0] V_MAX = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_LO = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] B1 = 10'(1 * H_VISIBLE / 8);
    localparam logic [9:0] B2 = 10'(2 * H_VISIBLE / 8);
    localparam logic [9:0] B3 = 10'(3 * H_VISIBLE / 8);
    localparam logic [9:0] B4 = 10'(4 * H_VISIBLE / 8);
    localparam logic [9:0] B5 = 10'(5 * H_VISIBLE / 8);
    localparam logic [9:0] B6 = 10'(6 * H_VISIBLE / 8);
    localparam logic [9:0] B7 = 10'(7 * H_VISIBLE / 8);

    logic       pe_q, pe_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic [4:0] red_q, red_d, blue_q, blue_d;
    logic [5:0] green_q, green_d;
    logic [2:0] bar;
    logic       vis;

    // Bar index bit 0 clears blue, bit 1 clears red, bit 2 clears green,
    // which yields white/yellow/cyan/green/magenta/red/blue/black in order.
    always_comb begin
        pe_d = ~pe_q;
        h_d = h_q;
        v_d = v_q;
        if (pe_q) begin
            h_d = (h_q == H_MAX) ? 10'd0 : h_q + 10'd1;
            if (h_q == H_MAX)
                v_d = (v_q == V_MAX) ? 10'd0 : v_q + 10'd1;
        end
        bar = (h_q < B1) ? 3'd0 : (h_q < B2) ? 3'd1 : (h_q < B3) ? 3'd2 :
              (h_q < B4) ? 3'd3 : (h_q < B5) ? 3'd4 : (h_q < B6) ? 3'd5 :
              (h_q < B7) ? 3'd6 : 3'd7;
        vis = (h_q < H_VIS) && (v_q < V_VIS);
        hsync_d = !((h_q >= HS_LO) && (h_q <= HS_HI));
        vsync_d = !((v_q >= VS_LO) && (v_q <= VS_HI));
        red_d = (vis && !bar[1]) ? 5'd31 : 5'd0;
        green_d = (vis && !bar[2]) ? 6'd63 : 6'd0;
        blue_d = (vis && !bar[0]) ? 5'd31 : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pe_q <= 1'b0;
            h_q <= 10'd0;
            v_q <= 10'd0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            red_q <= 5'd0;
            green_q <= 6'd0;
            blue_q <= 5'd0;
        end else begin
            pe_q <= pe_d;
            h_q <= h_d;
            v_q <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q <= red_d;
            green_q <= green_d;
            blue_q <= blue_d;
        end
    end

    assign Hsync = hsync_q;
    assign Vsync = vsync_q;
    assign Red = red_q;
    assign Green = green_q;
    assign Blue = blue_q;
endmodule

// File: tb/tb_top_mod.sv
// tb_top_mod: checks top_mod against an edge-count based pixel model.
module tb_top_mod;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hs_a, vs_a, hs_b, vs_b;
    logic [4:0] r_a, b_a, r_b, b_b;
    logic [5:0] g_a, g_b;
    int n = 0;
    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    top_mod dut_a (
        .clk(clk), .rst(rst), .Hsync(hs_a), .Vsync(vs_a),
        .Red(r_a), .Green(g_a), .Blue(b_a)
    );

    // Short-frame instance: 15 lines per frame so vertical sync, vertical
    // blanking and frame wrap are reachable in a short run.
    top_mod #(.V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_b (
        .clk(clk), .rst(rst), .Hsync(hs_b), .Vsync(vs_b),
        .Red(r_b), .Green(g_b), .Blue(b_b)
    );

    always #10 clk = ~clk;

    // n counts rising edges since reset release; 0 while rst is seen high.
    always @(posedge clk) begin
        started <= 1'b1;
        n <= rst ? 0 : n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // Output after edge n shows pixel q=(n-1)/2 of the frame in raster order.
    function automatic logic [17:0] model(int e, int vvis, int vfp, int vsy, int vtot);
        int q, h, v;
        logic hs, vs;
        logic [15:0] rgb;
        if (e == 0) return {2'b11, 16'h0};
        q = (e - 1) / 2;
        h = q % 800;
        v = (q / 800) % vtot;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= vvis + vfp && v < vvis + vfp + vsy);
        rgb = 16'h0;
        if (h < 640 && v < vvis)
            case (h / 80)
                0: rgb = {5'd31, 6'd63, 5'd31};
                1: rgb = {5'd31, 6'd63, 5'd0};
                2: rgb = {5'd0, 6'd63, 5'd31};
                3: rgb = {5'd0, 6'd63, 5'd0};
                4: rgb = {5'd31, 6'd0, 5'd31};
                5: rgb = {5'd31, 6'd0, 5'd0};
                6: rgb = {5'd0, 6'd0, 5'd31};
                default: rgb = 16'h0;
            endcase
        return {hs, vs, rgb};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("frame_a", {hs_a, vs_a, r_a, g_a, b_a}, model(n, 480, 10, 2, 525));
            chk("frame_b", {hs_b, vs_b, r_b, g_b, b_b}, model(n, 8, 2, 2, 15));
            if (n == 0) chk("reset_a", {hs_a, vs_a, r_a, g_a, b_a}, 18'h30000);
            if (n == 1) chk("white_e1", {r_a, g_a, b_a}, {5'd31, 6'd63, 5'd31});
            if (n == 161) chk("yellow_e161", {r_a, g_a, b_a}, {5'd31, 6'd63, 5'd0});
            if (n == 1120) chk("blue_e1120", {r_a, g_a, b_a}, {5'd0, 6'd0, 5'd31});
            if (n == 1121) chk("black_e1121", {r_a, g_a, b_a}, 16'h0);
            if (n == 1280) chk("last_vis_e1280", {r_a, g_a, b_a}, 16'h0);
            if (n == 1281) chk("blank_e1281", {r_a, g_a, b_a}, 16'h0);
            if (n == 1312) chk("hs_before", hs_a, 1'b1);
            if (n == 1313) chk("hs_fall", hs_a, 1'b0);
            if (n == 1504) chk("hs_last_low", hs_a, 1'b0);
            if (n == 1505) chk("hs_rise", hs_a, 1'b1);
            if (n == 16000) chk("vs_b_before", vs_b, 1'b1);
            if (n == 16001) chk("vs_b_fall", vs_b, 1'b0);
            if (n == 19200) chk("vs_b_last_low", vs_b, 1'b0);
            if (n == 19201) chk("vs_b_rise", vs_b, 1'b1);
            if (n == 24000) chk("b_vblank_end", {r_b, g_b, b_b}, 16'h0);
            if (n == 24001) chk("b_wrap", {hs_b, vs_b, r_b, g_b, b_b}, {2'b11, 5'd31, 6'd63, 5'd31});
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (27300) @(posedge clk);
        repeat ($urandom_range(0, 15000)) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (24200) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
